// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEFAULT_DATAWIDTH = 32;
  localparam int DEFAULT_ADDRWIDTH = 8;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; expired flags the last permitted wait cycle.
// Latency: counter registered, expired combinational from the count. No backpressure.
module apb_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] timeout,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of earlier wait cycles, so this is the timeout-th one
  assign expired = (count == timeout - 8'd1);

endmodule

// File: rtl/apb_master.sv
// Single-request APB master: IDLE -> SETUP -> ACCESS, with wait-state timeout.
// Latency: 3 cycles minimum request-to-response; req_ready low for the whole transfer.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ADDRWIDTH = DEFAULT_ADDRWIDTH,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [DATAWIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 PSEL1,
  output logic                 PSEL2,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic                 PREADY,
  input  logic [DATAWIDTH-1:0] PRDATA
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  apb_state_e state;
  logic       expired;
  logic       timer_clr;
  logic       timer_en;

  assign req_ready = (state == IDLE);
  assign timer_clr = req_ready && req_valid;
  assign timer_en  = (state == ACCESS) && !PREADY;

  apb_wait_timer u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (timer_clr),
    .enable  (timer_en),
    .timeout (TIMEOUT_CNT),
    .expired (expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      PSEL1      <= 1'b0;
      PSEL2      <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE <= req_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            // address MSB picks the slave
            PSEL1  <= !req_addr[ADDRWIDTH-1];
            PSEL2  <= req_addr[ADDRWIDTH-1];
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            state      <= IDLE;
            PSEL1      <= 1'b0;
            PSEL2      <= 1'b0;
            PENABLE    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= PWRITE ? '0 : PRDATA;
          end else if (expired) begin
            state      <= IDLE;
            PSEL1      <= 1'b0;
            PSEL2      <= 1'b0;
            PENABLE    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed vector table, back-to-back, reset abort, and random transfers vs. a transaction model.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .PSEL1      (PSEL1),
    .PSEL2      (PSEL2),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    int            exp_psel_cycles;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: waits below TIMEOUT complete normally, otherwise abort.
  task automatic model(input bit write, input int waits, input logic [DW-1:0] prdata,
                       output int psel_cycles, output bit err, output logic [DW-1:0] rdata);
    if (waits < TO) begin
      psel_cycles = 2 + waits;
      err         = 1'b0;
      rdata       = write ? '0 : prdata;
    end else begin
      psel_cycles = 1 + TO;
      err         = 1'b1;
      rdata       = '0;
    end
  endtask

  // Starts from IDLE just after an edge; runs a fixed number of cycles, so it cannot hang.
  task automatic run_xfer(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input logic [DW-1:0] prdata, input int exp_psel,
                          input bit exp_err, input logic [DW-1:0] exp_rdata);
    bit in_xfer;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    PREADY    = 1'($urandom);
    PRDATA    = $urandom;
    for (int c = 1; c <= exp_psel + 2; c++) begin
      @(posedge PCLK);
      #1;
      if (c == 1) begin
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
      end
      in_xfer = (c <= exp_psel);
      chk("psel1", 32'(PSEL1), 32'(in_xfer && !addr[AW-1]));
      chk("psel2", 32'(PSEL2), 32'(in_xfer && addr[AW-1]));
      chk("penable", 32'(PENABLE), 32'(c >= 2 && in_xfer));
      chk("req_ready", 32'(req_ready), 32'(!in_xfer));
      chk("paddr", 32'(PADDR), 32'(addr));
      chk("pwrite", 32'(PWRITE), 32'(write));
      chk("pwdata", PWDATA, wdata);
      chk("resp_valid", 32'(resp_valid), 32'(c == exp_psel + 1));
      if (c > exp_psel) begin
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
      if (c >= 2 && in_xfer && (c - 1) > waits) begin
        PREADY = 1'b1;
        PRDATA = prdata;
      end else if (c >= 2 && in_xfer) begin
        PREADY = 1'b0;
        PRDATA = $urandom;
      end else begin
        PREADY = 1'($urandom);
        PRDATA = $urandom;
      end
    end
  endtask

  logic [AW-1:0] bb_addr[3];
  int            m_psel;
  bit            m_err;
  logic [DW-1:0] m_rdata;
  bit            r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_prdata;
  int            r_waits;

  initial begin
    // write, addr, wdata, waits, prdata, psel cycles, err, rdata
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,   32'hFFFF0000, 2, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 8'h84, 32'h0,        3,   32'h12345678, 5, 1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 8'h20, 32'h0,        100, 32'hCAFEF00D, 5, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 8'h7F, 32'h0,        1,   32'h0BADC0DE, 3, 1'b0, 32'h0BADC0DE};
    vecs[4] = '{1'b1, 8'hFF, 32'h13579BDF, 3,   32'h11111111, 5, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 8'h80, 32'h0,        4,   32'h22222222, 5, 1'b1, 32'h0};

    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    @(posedge PCLK);
    #1;
    chk("rst_psel1", 32'(PSEL1), 32'd0);
    chk("rst_psel2", 32'(PSEL2), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    foreach (vecs[i])
      run_xfer(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prdata,
               vecs[i].exp_psel_cycles, vecs[i].exp_err, vecs[i].exp_rdata);

    // Back-to-back with req_valid held: the next request sits on the bus while busy.
    bb_addr[0] = 8'h05;
    bb_addr[1] = 8'h83;
    bb_addr[2] = 8'h41;
    PREADY     = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_wdata  = 32'hA0A0A0A0;
    req_addr   = bb_addr[0];
    for (int c = 1; c <= 9; c++) begin
      int idx;
      int ph;
      @(posedge PCLK);
      #1;
      idx = (c - 1) / 3;
      ph  = (c - 1) % 3;
      chk("b2b_paddr", 32'(PADDR), 32'(bb_addr[idx]));
      chk("b2b_req_ready", 32'(req_ready), 32'(ph == 2));
      chk("b2b_resp_valid", 32'(resp_valid), 32'(ph == 2));
      chk("b2b_penable", 32'(PENABLE), 32'(ph == 1));
      chk("b2b_psel2", 32'(PSEL2), 32'(ph != 2 && bb_addr[idx][AW-1]));
      if (ph == 0 && idx < 2) req_addr = bb_addr[idx + 1];
      if (c == 9) req_valid = 1'b0;
    end
    @(posedge PCLK);
    #1;
    chk("b2b_no_extra", 32'(req_ready), 32'd1);

    for (int n = 0; n < 30; n++) begin
      r_write  = 1'($urandom);
      r_addr   = AW'($urandom);
      r_wdata  = $urandom;
      r_prdata = $urandom;
      r_waits  = $urandom_range(0, 6);
      model(r_write, r_waits, r_prdata, m_psel, m_err, m_rdata);
      run_xfer(r_write, r_addr, r_wdata, r_waits, r_prdata, m_psel, m_err, m_rdata);
    end

    // Reset in the middle of ACCESS, then a normal read.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h22;
    req_wdata = 32'h55AA55AA;
    PREADY    = 1'b0;
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    @(posedge PCLK);
    #1;
    chk("mid_penable", 32'(PENABLE), 32'd1);
    #3;
    PRESET = 1'b1;
    #1;
    chk("arst_psel1", 32'(PSEL1), 32'd0);
    chk("arst_psel2", 32'(PSEL2), 32'd0);
    chk("arst_penable", 32'(PENABLE), 32'd0);
    chk("arst_pwrite", 32'(PWRITE), 32'd0);
    chk("arst_paddr", 32'(PADDR), 32'd0);
    chk("arst_pwdata", PWDATA, 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    chk("arst_resp_err", 32'(resp_err), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    #1;
    PRESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge PCLK);
      #1;
      chk("arst_no_resp", 32'(resp_valid), 32'd0);
    end
    run_xfer(1'b0, 8'h90, 32'h0, 2, 32'hA5A55A5A, 4, 1'b0, 32'hA5A55A5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
